// File: rtl/serial_tx_scheduler_pkg.sv
// Shared serial framing constants and transmit FSM state type.
// Also imported by the receive path (start-bit detect, S2P).
package serial_pkg;

  localparam int FRAME_BITS = 10;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  localparam logic [FRAME_BITS-1:0] IDLE_FRAME = 10'h3FF;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    DONE
  } tx_state_t;

  // Bit 0 leaves the shift register first, so the start bit sits in the LSB.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data);
    return {STOP_BIT, data, START_BIT};
  endfunction

endpackage

// File: rtl/serial_tx_scheduler_if.sv
// Host-side request bus and P2S control bundle for the transmit scheduler.
// The master side is the byte sources; the slave side is the scheduler.
interface serial_tx_scheduler_if #(
  parameter int NUM_REQ = 4
);
  import serial_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);

  logic                   transmit_enable;
  logic [NUM_REQ-1:0]     req;
  logic [8*NUM_REQ-1:0]   req_data;
  logic [NUM_REQ-1:0]     grant;
  logic                   p2s_load;
  logic [FRAME_BITS-1:0]  p2s_frame;
  logic                   p2s_shift;
  logic                   tx_active;
  logic                   char_sent;
  logic [IDX_W-1:0]       last_src;

  modport master (
    output transmit_enable, req, req_data,
    input  grant, p2s_load, p2s_frame, p2s_shift, tx_active, char_sent, last_src
  );

  modport slave (
    input  transmit_enable, req, req_data,
    output grant, p2s_load, p2s_frame, p2s_shift, tx_active, char_sent, last_src
  );

endinterface

// File: rtl/serial_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request at or after
// rr_ptr (wrapping) wins.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   winner
);

  logic [IDX_W-1:0]   cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] cand_req;

  // Candidate gi is the requester gi places after rr_ptr, wrapped without a divider.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    logic [IDX_W:0] sum;
    assign sum = {1'b0, rr_ptr} + (IDX_W+1)'(gi);
    assign cand_idx[gi] = (sum >= (IDX_W+1)'(NUM_REQ)) ?
                          IDX_W'(sum - (IDX_W+1)'(NUM_REQ)) : sum[IDX_W-1:0];
    assign cand_req[gi] = req[cand_idx[gi]];
  end

  always_comb begin
    valid  = |cand_req;
    winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cand_req[i]) begin
        winner = cand_idx[i];
      end
    end
  end

endmodule

// File: rtl/serial_tx_scheduler.sv
// Transmit scheduler: picks a requester round-robin, loads its framed byte
// into the P2S register and paces one shift every CLKS_PER_BIT clocks.
module serial_tx_scheduler
  import serial_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  serial_tx_scheduler_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int SC_W  = $clog2(CLKS_PER_BIT);

  tx_state_t             state_reg;
  logic [NUM_REQ-1:0]    grant_reg;
  logic                  p2s_load_reg;
  logic [FRAME_BITS-1:0] p2s_frame_reg;
  logic                  p2s_shift_reg;
  logic                  tx_active_reg;
  logic                  char_sent_reg;
  logic [IDX_W-1:0]      last_src_reg;
  logic [IDX_W-1:0]      rr_ptr_reg;
  logic [SC_W-1:0]       sample_cnt_reg;
  logic [3:0]            bit_cnt_reg;

  logic                  arb_valid;
  logic [IDX_W-1:0]      arb_winner;
  logic [7:0]            req_byte [NUM_REQ];
  logic [IDX_W-1:0]      rr_ptr_next;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
    assign req_byte[gi] = bus.req_data[8*gi +: 8];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req    (bus.req),
    .rr_ptr (rr_ptr_reg),
    .valid  (arb_valid),
    .winner (arb_winner)
  );

  assign rr_ptr_next = (last_src_reg == IDX_W'(NUM_REQ - 1)) ? '0 : last_src_reg + IDX_W'(1);

  // Outputs are registered, so every pulse is set on the edge that enters its cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      p2s_load_reg   <= 1'b0;
      p2s_frame_reg  <= IDLE_FRAME;
      p2s_shift_reg  <= 1'b0;
      tx_active_reg  <= 1'b0;
      char_sent_reg  <= 1'b0;
      last_src_reg   <= '0;
      rr_ptr_reg     <= '0;
      sample_cnt_reg <= '0;
      bit_cnt_reg    <= '0;
    end else begin
      grant_reg     <= '0;
      p2s_load_reg  <= 1'b0;
      p2s_shift_reg <= 1'b0;
      char_sent_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.transmit_enable && arb_valid) begin
            state_reg     <= LOAD;
            grant_reg     <= NUM_REQ'(1) << arb_winner;
            p2s_load_reg  <= 1'b1;
            p2s_frame_reg <= build_frame(req_byte[arb_winner]);
            tx_active_reg <= 1'b1;
            last_src_reg  <= arb_winner;
          end
        end
        LOAD: begin
          sample_cnt_reg <= '0;
          bit_cnt_reg    <= '0;
          state_reg      <= SEND;
        end
        SEND: begin
          if (sample_cnt_reg == SC_W'(CLKS_PER_BIT - 1)) begin
            sample_cnt_reg <= '0;
            bit_cnt_reg    <= bit_cnt_reg + 4'd1;
            if (bit_cnt_reg == 4'(FRAME_BITS - 1)) begin
              state_reg     <= DONE;
              char_sent_reg <= 1'b1;
              tx_active_reg <= 1'b0;
            end
          end else begin
            sample_cnt_reg <= sample_cnt_reg + SC_W'(1);
            // Raise the shift so it is visible in the cycle the counter hits its top.
            if (sample_cnt_reg == SC_W'(CLKS_PER_BIT - 2)) begin
              p2s_shift_reg <= 1'b1;
            end
          end
        end
        DONE: begin
          rr_ptr_reg <= rr_ptr_next;
          state_reg  <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.grant     = grant_reg;
  assign bus.p2s_load  = p2s_load_reg;
  assign bus.p2s_frame = p2s_frame_reg;
  assign bus.p2s_shift = p2s_shift_reg;
  assign bus.tx_active = tx_active_reg;
  assign bus.char_sent = char_sent_reg;
  assign bus.last_src  = last_src_reg;

endmodule

// File: doc/serial_tx_scheduler.md
Name: serial_tx_scheduler

Overview:
- Controller for the shared serial transmit datapath: the P2S shift register plus bit sampling and bit identification counting.
- Arbitrates round-robin among NUM_REQ requesters and latches the winner's byte.
- Builds a 10-bit frame (start 0, 8 data LSB-first, stop 1) and sequences P2S load/shift at one bit per CLKS_PER_BIT clocks.
- Sits in TopLevel between the host-side byte sources and P2S_ShiftRegister; replaces the ad hoc transmit_enable/load driving.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CLKS_PER_BIT, 16, clocks per serial bit; matches the receive-side sample rate.

Ports:
- clk  in  1  system clock; everything is on posedge.
- reset  in  1  asynchronous, active-high reset.
- transmit_enable  in  1  permits starting a new frame; does not abort a frame in progress.
- req  in  NUM_REQ  per-requester send request, level-held until granted.
- req_data  in  8*NUM_REQ  byte for requester i in bits [8i+7:8i].
- grant  out  NUM_REQ  one-hot, 1-cycle pulse: requester's byte accepted.
- p2s_load  out  1  1-cycle pulse: load p2s_frame into P2S.
- p2s_frame  out  10  {1'b1, data[7:0], 1'b0}; bit0 is sent first.
- p2s_shift  out  1  1-cycle pulse: advance P2S by one bit; P2S shifts in 1 for line idle.
- tx_active  out  1  high from LOAD through SEND.
- char_sent  out  1  1-cycle pulse when a frame completes.
- last_src  out  $clog2(NUM_REQ)  index of the most recent grant.

Behaviour:
- Reset (async, immediate): state=IDLE. grant=0, p2s_load=0, p2s_shift=0, tx_active=0, char_sent=0, p2s_frame=10'h3FF, last_src=0, rr_ptr=0, sample_cnt=0, bit_cnt=0.
- IDLE:
  - If transmit_enable && |req: winner = first requester with req=1 searching rr_ptr, rr_ptr+1, … wrapping mod NUM_REQ.
  - Register the winner index and byte, then go to LOAD next cycle.
  - Otherwise stay in IDLE.
- LOAD (1 cycle):
  - grant[winner]=1, p2s_load=1, p2s_frame={1,byte,0}, tx_active=1, last_src=winner.
  - Clear sample_cnt and bit_cnt; go to SEND.
- SEND:
  - sample_cnt increments each cycle 0..CLKS_PER_BIT-1.
  - At CLKS_PER_BIT-1: p2s_shift=1 for that cycle, sample_cnt wraps to 0, bit_cnt++.
  - After the shift that makes bit_cnt=10, go to DONE.
- DONE (1 cycle): char_sent=1, tx_active=0, rr_ptr=(winner+1) mod NUM_REQ, go to IDLE.
- Timing, with LOAD at cycle T:
  - p2s_shift at T+16k, k=1..10.
  - char_sent at T+161.
  - Earliest next LOAD at T+163 (IDLE decision cycle at T+162).
- Sampling and data rules:
  - Requests are sampled only in IDLE.
  - A req that drops before its grant is never granted.
  - req_data is captured in the IDLE decision cycle; changes during SEND are ignored.
  - A requester that keeps req high after its grant is served again only after the other pending requesters (fairness).
- transmit_enable dropping during LOAD/SEND: frame completes normally; no new frame starts until it is high again.
- Reset mid-frame: abort immediately. No char_sent, no further shifts. p2s_frame=3FF so the line idles high.
- All of req=0 or transmit_enable=0: no outputs toggle; counters hold at 0.
- Widths: sample_cnt is $clog2(CLKS_PER_BIT) bits; bit_cnt is 4 bits. Both saturate-free; they are only cleared in LOAD.

Decomposition:
- Package serial_pkg:
  - FRAME_BITS=10, START_BIT=1'b0, STOP_BIT=1'b1, IDLE_FRAME=10'h3FF.
  - typedef enum tx_state_t {IDLE, LOAD, SEND, DONE}.
  - Shared with the receive path (start-bit detect, S2P).
- Sub-module rr_arbiter:
  - Parameterised NUM_REQ; purely combinational.
  - Inputs req, rr_ptr; outputs valid, winner index.
- The scheduler keeps the FSM, counters and rr_ptr register.

Test Plan:
1. Reset, then req=4'b0001, req_data[7:0]=8'hA5, transmit_enable=1.
   - grant=0001 and p2s_load with p2s_frame=10'b1_10100101_0.
   - 10 p2s_shift pulses spaced 16 clocks apart.
   - char_sent exactly 161 cycles after p2s_load; last_src=0.
2. req=4'b1111 held, bytes 11/22/33/44.
   - Grants in order 0,1,2,3,0 with frames carrying 11,22,33,44,11.
   - One char_sent per frame; consecutive p2s_load pulses 163 cycles apart.
3. transmit_enable=0 with req=4'b0100.
   - No grant, no p2s_load, tx_active stays 0.
   - Raise enable: grant=0100 within 2 cycles.
4. Drop transmit_enable at shift 5 of a frame.
   - Remaining 5 shifts and char_sent still occur; no next grant while enable=0.
5. Assert reset at shift 3.
   - All outputs return to reset values in the same cycle (async); p2s_frame=3FF.
   - After release with req pending: grant to index 0 (rr_ptr=0).
6. Change req_data during SEND, and drop req[2] while requester 1 is being served.
   - Transmitted frame is unchanged.
   - Requester 2 is never granted; next grant goes to the next pending index after 1.
